// File: rtl/jk_loader_pkg.sv
// Shared types and constants for the JK state loader.
package jk_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_t;

    // Per-bit excitation codes, packed as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Width of the retry counter: enough to hold 0..max_retry, at least one bit
    function automatic int retry_width(input int max_retry);
        int w;
        w = $clog2(max_retry + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: derives J/K per bit from current Q and target.
// Build option JK_TOGGLE_EXC_EN: changing bits use toggle (J=K=1) instead of set/reset.
module jk_excite
    import jk_loader_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

`ifdef JK_TOGGLE_EXC_EN
    localparam logic [1:0] UP_CODE   = JK_TGL;
    localparam logic [1:0] DOWN_CODE = JK_TGL;
`else
    localparam logic [1:0] UP_CODE   = JK_SET;
    localparam logic [1:0] DOWN_CODE = JK_RST;
`endif

    // Excitation for a single flop; don't-cares resolve to hold (0,0)
    function automatic logic [1:0] excite_bit(input logic q_b, input logic t_b);
        logic [1:0] code;
        case ({q_b, t_b})
            2'b01:   code = UP_CODE;
            2'b10:   code = DOWN_CODE;
            default: code = JK_HOLD;
        endcase
        return code;
    endfunction

    // Apply the per-bit excitation across the whole bank
    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = excite_bit(q[i], target[i]);
        end
    end

endmodule

// File: rtl/jk_state_loader.sv
// Drives a bank of JK flops (shared enable) to a requested target word,
// verifying the result and retrying up to MAX_RETRY extra times.
// Optional build macro: JK_TOGGLE_EXC_EN (toggle excitation, see jk_excite).
module jk_state_loader
    import jk_loader_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_in,
    output logic             en_out,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int RW = retry_width(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE   = RW'(1);

    state_t           state_r, state_s;
    logic [RW-1:0]    retry_r, retry_s;
    logic [WIDTH-1:0] target_r, target_s;
    logic             en_r, en_s;
    logic [WIDTH-1:0] j_r, j_s;
    logic [WIDTH-1:0] k_r, k_s;
    logic             done_r, done_s;
    logic             error_r, error_s;

    logic [WIDTH-1:0] exc_target_s;
    logic [WIDTH-1:0] exc_j_s;
    logic [WIDTH-1:0] exc_k_s;

    // Excitation target: the incoming word when accepting, the latched word when retrying
    always_comb begin
        exc_target_s = target_r;
        case (state_r)
            IDLE:    exc_target_s = in_target;
            default: exc_target_s = target_r;
        endcase
    end

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .q      (q_in),
        .target (exc_target_s),
        .j      (exc_j_s),
        .k      (exc_k_s)
    );

    // Next-state and next-output logic for the loader FSM
    always_comb begin
        state_s  = state_r;
        retry_s  = retry_r;
        target_s = target_r;
        en_s     = 1'b0;
        j_s      = '0;
        k_s      = '0;
        done_s   = 1'b0;
        error_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    target_s = in_target;
                    en_s     = 1'b1;
                    j_s      = exc_j_s;
                    k_s      = exc_k_s;
                    retry_s  = '0;
                    state_s  = DRIVE;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRIVE: begin
                // Flops update on the closing edge of this cycle; verify next
                state_s = CHECK;
            end
            CHECK: begin
                if (q_in == target_r) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (retry_r < RETRY_LIMIT) begin
                    retry_s = retry_r + RETRY_ONE;
                    en_s    = 1'b1;
                    j_s     = exc_j_s;
                    k_s     = exc_k_s;
                    state_s = DRIVE;
                end else begin
                    error_s = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            retry_r  <= '0;
            target_r <= '0;
            en_r     <= 1'b0;
            j_r      <= '0;
            k_r      <= '0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            retry_r  <= retry_s;
            target_r <= target_s;
            en_r     <= en_s;
            j_r      <= j_s;
            k_r      <= k_s;
            done_r   <= done_s;
            error_r  <= error_s;
        end
    end

    assign in_ready = (state_r == IDLE);
    assign busy     = (state_r != IDLE);
    assign en_out   = en_r;
    assign j_out    = j_r;
    assign k_out    = k_r;
    assign done     = done_r;
    assign error    = error_r;

endmodule
